// File: rtl/apb_logic_op_pkg.sv
// Shared types for the logic-op APB master: register map, opcodes, FSM states.
// Helpers map a sequence step to its slave offset and write data.
package apb_logic_op_pkg;

  localparam logic [31:0] ADDR_OP1  = 32'h0;
  localparam logic [31:0] ADDR_OP2  = 32'h4;
  localparam logic [31:0] ADDR_CTRL = 32'h8;
  localparam logic [31:0] ADDR_RES  = 32'hC;

  typedef enum logic [1:0] {
    OP_NONE = 2'd0,
    OP_AND  = 2'd1,
    OP_OR   = 2'd2,
    OP_XOR  = 2'd3
  } opcode_e;

  // Transfer-engine states; RESP belongs to the command sequencer.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SETUP  = 3'd1,
    ST_ACCESS = 3'd2,
    ST_GAP    = 3'd3,
    ST_RESP   = 3'd4
  } state_e;

  typedef enum logic [1:0] {
    SEQ_IDLE = 2'd0,
    SEQ_RUN  = 2'd1,
    SEQ_RESP = 2'd2
  } seq_state_e;

  localparam logic [1:0] STEP_RES = 2'd3;

  function automatic logic [31:0] step_offset(input logic [1:0] step);
    logic [31:0] off;
    case (step)
      2'd0:    off = ADDR_OP1;
      2'd1:    off = ADDR_OP2;
      2'd2:    off = ADDR_CTRL;
      default: off = ADDR_RES;
    endcase
    return off;
  endfunction

  function automatic logic [31:0] step_wdata(input logic [1:0]  step,
                                             input logic [31:0] op1,
                                             input logic [31:0] op2,
                                             input opcode_e     opc);
    logic [31:0] wd;
    case (step)
      2'd0:    wd = op1;
      2'd1:    wd = op2;
      2'd2:    wd = {30'b0, opc};
      default: wd = 32'h0;
    endcase
    return wd;
  endfunction

endpackage

// File: rtl/apb_master_xfer.sv
// Single APB transfer engine: SETUP, ACCESS until PREADY or timeout, then one GAP cycle.
// Latency: 1 SETUP + >=1 ACCESS + 1 GAP; a start accepted in GAP chains straight into SETUP.
// Backpressure: stalls in ACCESS while PREADY is low, aborting with err after TIMEOUT_CYCLES.
module apb_master_xfer
  import apb_logic_op_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] start_addr,
  input  logic        start_write,
  input  logic [31:0] start_wdata,
  output logic        psel,
  output logic        penable,
  output logic        pwrite,
  output logic [31:0] paddr,
  output logic [31:0] pwdata,
  input  logic [31:0] prdata,
  input  logic        pready,
  input  logic        pslverr,
  output logic        done,
  output logic        err,
  output logic [31:0] rdata
);

  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_e      state_q, state_d;
  logic [7:0]  tmo_q, tmo_d;
  logic [31:0] paddr_q, paddr_d;
  logic [31:0] pwdata_q, pwdata_d;
  logic        pwrite_q, pwrite_d;
  logic        err_q, err_d;
  logic [31:0] rdata_q, rdata_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      tmo_q    <= 8'd0;
      paddr_q  <= 32'h0;
      pwdata_q <= 32'h0;
      pwrite_q <= 1'b0;
      err_q    <= 1'b0;
      rdata_q  <= 32'h0;
    end else begin
      state_q  <= state_d;
      tmo_q    <= tmo_d;
      paddr_q  <= paddr_d;
      pwdata_q <= pwdata_d;
      pwrite_q <= pwrite_d;
      err_q    <= err_d;
      rdata_q  <= rdata_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    tmo_d    = tmo_q;
    paddr_d  = paddr_q;
    pwdata_d = pwdata_q;
    pwrite_d = pwrite_q;
    err_d    = err_q;
    rdata_d  = rdata_q;
    case (state_q)
      ST_IDLE, ST_GAP: begin
        state_d = ST_IDLE;
        if (start) begin
          state_d  = ST_SETUP;
          paddr_d  = start_addr;
          pwdata_d = start_wdata;
          pwrite_d = start_write;
          err_d    = 1'b0;
          rdata_d  = 32'h0;
        end
      end
      ST_SETUP: begin
        state_d = ST_ACCESS;
        tmo_d   = 8'd0;
      end
      ST_ACCESS: begin
        if (pready) begin
          state_d = ST_GAP;
          if (pslverr) begin
            err_d   = 1'b1;
            rdata_d = 32'h0;
          end else if (!pwrite_q) begin
            rdata_d = prdata;
          end
        end else if (tmo_q == TMO_LAST) begin
          state_d = ST_GAP;
          err_d   = 1'b1;
          rdata_d = 32'h0;
        end else begin
          tmo_d = tmo_q + 8'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign psel    = (state_q == ST_SETUP) || (state_q == ST_ACCESS);
  assign penable = (state_q == ST_ACCESS);
  assign pwrite  = pwrite_q;
  assign paddr   = paddr_q;
  assign pwdata  = pwdata_q;
  assign done    = (state_q == ST_GAP);
  assign err     = err_q;
  assign rdata   = rdata_q;

endmodule

// File: rtl/apb_logic_op_master.sv
// Runs one logic-op command as wr op1, wr op2, wr control, rd result over APB.
// Latency: four transfers of SETUP+ACCESS+GAP, then RESP until rsp_ready.
// Backpressure: cmd_ready only in IDLE; response held stable until rsp_ready.
module apb_logic_op_master
  import apb_logic_op_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 16,
  parameter logic [31:0] BASE_ADDR      = 32'h0
) (
  input  logic        PCLK,
  input  logic        PRESET,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [31:0] cmd_op1,
  input  logic [31:0] cmd_op2,
  input  logic [1:0]  cmd_opcode,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_data,
  output logic        rsp_err,
  output logic        PSEL,
  output logic        PENABLE,
  output logic        PWRITE,
  output logic [31:0] PADDR,
  output logic [31:0] PWDATA,
  input  logic [31:0] PRDATA,
  input  logic        PREADY,
  input  logic        PSLVERR
);

  seq_state_e  seq_q, seq_d;
  logic [1:0]  step_q, step_d;
  logic [31:0] op1_q, op1_d;
  logic [31:0] op2_q, op2_d;
  opcode_e     opc_q, opc_d;
  logic [31:0] rsp_data_q, rsp_data_d;
  logic        rsp_err_q, rsp_err_d;

  logic        xfer_start;
  logic [1:0]  xfer_step;
  logic [31:0] src_op1, src_op2;
  opcode_e     src_opc;
  logic [31:0] xfer_addr, xfer_wdata;
  logic        xfer_write;
  logic        xfer_done, xfer_err;
  logic [31:0] xfer_rdata;

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      seq_q      <= SEQ_IDLE;
      step_q     <= 2'd0;
      op1_q      <= 32'h0;
      op2_q      <= 32'h0;
      opc_q      <= OP_NONE;
      rsp_data_q <= 32'h0;
      rsp_err_q  <= 1'b0;
    end else begin
      seq_q      <= seq_d;
      step_q     <= step_d;
      op1_q      <= op1_d;
      op2_q      <= op2_d;
      opc_q      <= opc_d;
      rsp_data_q <= rsp_data_d;
      rsp_err_q  <= rsp_err_d;
    end
  end

  always_comb begin
    seq_d      = seq_q;
    step_d     = step_q;
    op1_d      = op1_q;
    op2_d      = op2_q;
    opc_d      = opc_q;
    rsp_data_d = rsp_data_q;
    rsp_err_d  = rsp_err_q;
    xfer_start = 1'b0;
    xfer_step  = step_q;
    src_op1    = op1_q;
    src_op2    = op2_q;
    src_opc    = opc_q;
    case (seq_q)
      SEQ_IDLE: begin
        // The first transfer launches from the live command so SETUP follows the handshake directly.
        if (cmd_valid) begin
          op1_d      = cmd_op1;
          op2_d      = cmd_op2;
          opc_d      = opcode_e'(cmd_opcode);
          step_d     = 2'd0;
          seq_d      = SEQ_RUN;
          xfer_start = 1'b1;
          xfer_step  = 2'd0;
          src_op1    = cmd_op1;
          src_op2    = cmd_op2;
          src_opc    = opcode_e'(cmd_opcode);
        end
      end
      SEQ_RUN: begin
        if (xfer_done) begin
          if (xfer_err) begin
            rsp_err_d  = 1'b1;
            rsp_data_d = 32'h0;
            seq_d      = SEQ_RESP;
          end else if (step_q == STEP_RES) begin
            rsp_err_d  = 1'b0;
            rsp_data_d = xfer_rdata;
            seq_d      = SEQ_RESP;
          end else begin
            step_d     = step_q + 2'd1;
            xfer_start = 1'b1;
            xfer_step  = step_q + 2'd1;
          end
        end
      end
      SEQ_RESP: begin
        if (rsp_ready) seq_d = SEQ_IDLE;
      end
      default: seq_d = SEQ_IDLE;
    endcase
  end

  assign xfer_addr  = BASE_ADDR + step_offset(xfer_step);
  assign xfer_write = (xfer_step != STEP_RES);
  assign xfer_wdata = step_wdata(xfer_step, src_op1, src_op2, src_opc);

  apb_master_xfer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_xfer (
    .clk        (PCLK),
    .rst        (PRESET),
    .start      (xfer_start),
    .start_addr (xfer_addr),
    .start_write(xfer_write),
    .start_wdata(xfer_wdata),
    .psel       (PSEL),
    .penable    (PENABLE),
    .pwrite     (PWRITE),
    .paddr      (PADDR),
    .pwdata     (PWDATA),
    .prdata     (PRDATA),
    .pready     (PREADY),
    .pslverr    (PSLVERR),
    .done       (xfer_done),
    .err        (xfer_err),
    .rdata      (xfer_rdata)
  );

  assign cmd_ready = (seq_q == SEQ_IDLE);
  assign rsp_valid = (seq_q == SEQ_RESP);
  assign rsp_data  = rsp_data_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_apb_logic_op_master.sv
// Directed bench for apb_logic_op_master with a behavioural logic-op slave stub.
module tb_apb_logic_op_master;

  logic        PCLK = 1'b0;
  logic        PRESET;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [31:0] cmd_op1, cmd_op2;
  logic [1:0]  cmd_opcode;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_data;
  logic        rsp_err;
  logic        PSEL, PENABLE, PWRITE;
  logic [31:0] PADDR, PWDATA, PRDATA;
  logic        PREADY, PSLVERR;

  int checks = 0;
  int errors = 0;

  always #5 PCLK = ~PCLK;

  apb_logic_op_master #(
    .TIMEOUT_CYCLES(16),
    .BASE_ADDR     (32'h0)
  ) dut (
    .PCLK      (PCLK),
    .PRESET    (PRESET),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op1   (cmd_op1),
    .cmd_op2   (cmd_op2),
    .cmd_opcode(cmd_opcode),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_err   (rsp_err),
    .PSEL      (PSEL),
    .PENABLE   (PENABLE),
    .PWRITE    (PWRITE),
    .PADDR     (PADDR),
    .PWDATA    (PWDATA),
    .PRDATA    (PRDATA),
    .PREADY    (PREADY),
    .PSLVERR   (PSLVERR)
  );

  // Slave stub: configurable wait states, error address and permanent stall.
  int          cfg_waits = 0;
  bit          cfg_stall = 1'b0;
  bit          cfg_err_en = 1'b0;
  logic [31:0] cfg_err_addr = 32'h0;
  int          wcnt = 0;
  logic [31:0] s_op1 = 32'h0, s_op2 = 32'h0, s_res = 32'h0;

  assign PREADY  = PSEL && PENABLE && !cfg_stall && (wcnt == cfg_waits);
  assign PSLVERR = PREADY && cfg_err_en && (PADDR == cfg_err_addr);
  assign PRDATA  = (PADDR == 32'hC) ? s_res : 32'hDEAD_BEEF;

  always @(posedge PCLK) begin
    if (PSEL && PENABLE && !PREADY) wcnt <= wcnt + 1;
    else wcnt <= 0;
    if (PSEL && PENABLE && PREADY && PWRITE && !PSLVERR) begin
      case (PADDR)
        32'h0: s_op1 <= PWDATA;
        32'h4: s_op2 <= PWDATA;
        32'h8: begin
          case (PWDATA[1:0])
            2'd1:    s_res <= s_op1 & s_op2;
            2'd2:    s_res <= s_op1 | s_op2;
            2'd3:    s_res <= s_op1 ^ s_op2;
            default: s_res <= 32'h0;
          endcase
        end
        default: ;
      endcase
    end
  end

  // Bus monitor: logs every SETUP, measures ACCESS length, flags missing gaps.
  int          n_setup = 0, gap_viol = 0, busy_viol = 0, acc_run = 0, last_acc = 0;
  bit          prev_acc = 1'b0;
  logic [31:0] log_addr [256];
  logic [31:0] log_wdata[256];
  logic        log_write[256];

  always @(posedge PCLK) begin
    if (PSEL && !PENABLE) begin
      log_addr[8'(n_setup)]  = PADDR;
      log_wdata[8'(n_setup)] = PWDATA;
      log_write[8'(n_setup)] = PWRITE;
      n_setup++;
    end
    if (prev_acc && PSEL && !PENABLE) gap_viol++;
    if (PSEL && cmd_ready) busy_viol++;
    if (PSEL && PENABLE) acc_run++;
    else begin
      if (acc_run != 0) last_acc = acc_run;
      acc_run = 0;
    end
    prev_acc = PSEL && PENABLE;
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  typedef struct {
    string       name;
    logic [31:0] op1;
    logic [31:0] op2;
    logic [1:0]  opc;
    int          waits;
    bit          err_en;
    logic [31:0] err_addr;
    bit          stall;
    logic [31:0] exp_data;
    bit          exp_err;
    int          exp_nxfer;
    int          exp_last_acc;
  } vec_t;

  function automatic vec_t mk(string nm, logic [31:0] a, logic [31:0] b, logic [1:0] opc,
                              int waits, bit err_en, logic [31:0] err_addr, bit stall,
                              logic [31:0] exp_data, bit exp_err, int nx, int last);
    vec_t v;
    v.name = nm; v.op1 = a; v.op2 = b; v.opc = opc; v.waits = waits;
    v.err_en = err_en; v.err_addr = err_addr; v.stall = stall;
    v.exp_data = exp_data; v.exp_err = exp_err; v.exp_nxfer = nx; v.exp_last_acc = last;
    return v;
  endfunction

  task automatic run_vec(input vec_t v, input int hold);
    int          base, gv0, bv0;
    bit          got;
    logic [31:0] exp_wd;
    cfg_waits    = v.waits;
    cfg_stall    = v.stall;
    cfg_err_en   = v.err_en;
    cfg_err_addr = v.err_addr;
    rsp_ready    = (hold == 0);
    base = n_setup; gv0 = gap_viol; bv0 = busy_viol;
    @(negedge PCLK);
    check({v.name, " cmd_ready_idle"}, 32'(cmd_ready), 32'd1);
    cmd_valid  = 1'b1;
    cmd_op1    = v.op1;
    cmd_op2    = v.op2;
    cmd_opcode = v.opc;
    @(posedge PCLK);
    #1;
    // Scramble the command inputs: the DUT must work from its latched copy.
    cmd_valid  = 1'b0;
    cmd_op1    = ~v.op1;
    cmd_op2    = ~v.op2;
    cmd_opcode = ~v.opc;
    got = 1'b0;
    for (int i = 0; i < 400 && !got; i++) begin
      @(negedge PCLK);
      if (rsp_valid) got = 1'b1;
    end
    check({v.name, " rsp_valid_seen"}, 32'(got), 32'd1);
    check({v.name, " rsp_data"}, rsp_data, v.exp_data);
    check({v.name, " rsp_err"}, 32'(rsp_err), 32'(v.exp_err));
    check({v.name, " n_xfer"}, 32'(n_setup - base), 32'(v.exp_nxfer));
    check({v.name, " last_access_len"}, 32'(last_acc), 32'(v.exp_last_acc));
    check({v.name, " gap_violations"}, 32'(gap_viol - gv0), 32'd0);
    check({v.name, " cmd_ready_while_busy"}, 32'(busy_viol - bv0), 32'd0);
    for (int i = 0; i < v.exp_nxfer; i++) begin
      case (i)
        0:       exp_wd = v.op1;
        1:       exp_wd = v.op2;
        2:       exp_wd = {30'b0, v.opc};
        default: exp_wd = 32'h0;
      endcase
      check($sformatf("%s xfer%0d addr", v.name, i), log_addr[8'(base + i)], 32'(4 * i));
      check($sformatf("%s xfer%0d write", v.name, i), 32'(log_write[8'(base + i)]), 32'(i != 3));
      check($sformatf("%s xfer%0d wdata", v.name, i), log_wdata[8'(base + i)], exp_wd);
    end
    for (int h = 0; h < hold; h++) begin
      @(negedge PCLK);
      check($sformatf("%s hold%0d rsp_valid", v.name, h), 32'(rsp_valid), 32'd1);
      check($sformatf("%s hold%0d rsp_data", v.name, h), rsp_data, v.exp_data);
      check($sformatf("%s hold%0d rsp_err", v.name, h), 32'(rsp_err), 32'(v.exp_err));
      check($sformatf("%s hold%0d cmd_ready", v.name, h), 32'(cmd_ready), 32'd0);
    end
    rsp_ready = 1'b1;
    @(posedge PCLK);
    @(negedge PCLK);
    check({v.name, " rsp_valid_after_ack"}, 32'(rsp_valid), 32'd0);
    check({v.name, " cmd_ready_after_ack"}, 32'(cmd_ready), 32'd1);
  endtask

  vec_t vecs[6];

  initial begin
    bit found;
    int stray;

    vecs[0] = mk("and",     32'hF0F0_F0F0, 32'hFF00_FF00, 2'd1, 0, 1'b0, 32'h0, 1'b0,
                 32'hF000_F000, 1'b0, 4, 1);
    vecs[1] = mk("or",      32'h0000_00FF, 32'h0000_FF00, 2'd2, 2, 1'b0, 32'h0, 1'b0,
                 32'h0000_FFFF, 1'b0, 4, 3);
    vecs[2] = mk("xor",     32'hAAAA_AAAA, 32'hFFFF_FFFF, 2'd3, 1, 1'b0, 32'h0, 1'b0,
                 32'h5555_5555, 1'b0, 4, 2);
    vecs[3] = mk("none",    32'h1234_5678, 32'h9ABC_DEF0, 2'd0, 0, 1'b0, 32'h0, 1'b0,
                 32'h0000_0000, 1'b0, 4, 1);
    vecs[4] = mk("slverr",  32'h0000_0001, 32'h0000_0001, 2'd1, 0, 1'b1, 32'h4, 1'b0,
                 32'h0000_0000, 1'b1, 2, 1);
    vecs[5] = mk("timeout", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'd1, 0, 1'b0, 32'h0, 1'b1,
                 32'h0000_0000, 1'b1, 1, 16);

    PRESET = 1'b1; cmd_valid = 1'b0; cmd_op1 = 32'h0; cmd_op2 = 32'h0;
    cmd_opcode = 2'd0; rsp_ready = 1'b0;
    repeat (2) @(posedge PCLK);
    @(negedge PCLK);
    check("reset PSEL", 32'(PSEL), 32'd0);
    check("reset PENABLE", 32'(PENABLE), 32'd0);
    check("reset PWRITE", 32'(PWRITE), 32'd0);
    check("reset PADDR", PADDR, 32'h0);
    check("reset PWDATA", PWDATA, 32'h0);
    check("reset rsp_valid", 32'(rsp_valid), 32'd0);
    check("reset rsp_data", rsp_data, 32'h0);
    check("reset rsp_err", 32'(rsp_err), 32'd0);
    check("reset cmd_ready", 32'(cmd_ready), 32'd1);
    PRESET = 1'b0;

    for (int i = 0; i < 6; i++) run_vec(vecs[i], 0);

    run_vec(vecs[2], 10);

    // Reset while the control write sits in ACCESS.
    cfg_waits = 2; cfg_stall = 1'b0; cfg_err_en = 1'b0;
    rsp_ready = 1'b1;
    @(negedge PCLK);
    cmd_valid = 1'b1; cmd_op1 = 32'h0F0F_0F0F; cmd_op2 = 32'h00FF_00FF; cmd_opcode = 2'd1;
    @(posedge PCLK);
    #1 cmd_valid = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      @(negedge PCLK);
      if (PSEL && PENABLE && PADDR == 32'h8) found = 1'b1;
    end
    check("rst_mid ctrl_access_seen", 32'(found), 32'd1);
    PRESET = 1'b1;
    @(posedge PCLK);
    @(negedge PCLK);
    check("rst_mid PSEL", 32'(PSEL), 32'd0);
    check("rst_mid PENABLE", 32'(PENABLE), 32'd0);
    check("rst_mid cmd_ready", 32'(cmd_ready), 32'd1);
    check("rst_mid rsp_valid", 32'(rsp_valid), 32'd0);
    PRESET = 1'b0;
    stray = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge PCLK);
      if (rsp_valid || PSEL) stray++;
    end
    check("rst_mid no_activity_after", 32'(stray), 32'd0);
    run_vec(vecs[0], 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
